// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: holds the core in reset, loads a length-prefixed little-endian
// byte image into instruction memory, then releases the core until the next boot_req.
module imem_boot_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              boot_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              err
);

    localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_HDR0    = 3'd0,
        S_HDR1    = 3'd1,
        S_LOAD    = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_hdr0;
    logic [1:0]          r_lane;
    logic [ADDR_W-1:0]   r_wcnt;
    logic [ADDR_W-1:0]   r_last;
    logic [23:0]         r_word;
    logic [IDLE_W-1:0]   r_idle;
    logic                w_accept;
    logic                w_counting;
    logic                w_timeout;
    logic                w_write;
    logic                w_count_ok;
    logic [16:0]         w_count;

    assign rx_ready   = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_LOAD);
    assign w_accept   = rx_valid && rx_ready;
    assign w_counting = (r_state == S_HDR1) || (r_state == S_LOAD);
    assign w_count    = {1'b0, rx_data, r_hdr0};
    assign w_count_ok = (w_count != 17'd0) && (w_count <= MAX_WORDS);
    assign w_timeout  = w_counting && !w_accept && (r_idle == IDLE_W'(TIMEOUT - 1));
    // A boot_req on the 4th byte discards the word instead of writing it
    assign w_write    = (r_state == S_LOAD) && w_accept && (r_lane == 2'd3) && !boot_req;

    // Next-state decode; boot_req overrides everything, then timeout
    always_comb begin
        w_next = r_state;
        if (boot_req) begin
            w_next = S_HDR0;
        end else if (w_timeout) begin
            w_next = S_ERR;
        end else begin
            case (r_state)
                S_HDR0: begin
                    if (w_accept) w_next = S_HDR1;
                    else          w_next = S_HDR0;
                end
                S_HDR1: begin
                    if (w_accept) w_next = w_count_ok ? S_LOAD : S_ERR;
                    else          w_next = S_HDR1;
                end
                S_LOAD: begin
                    if (w_write && (r_wcnt == r_last)) w_next = S_RELEASE;
                    else                               w_next = S_LOAD;
                end
                S_RELEASE: w_next = S_RUN;
                S_RUN:     w_next = S_RUN;
                S_ERR:     w_next = S_ERR;
                default:   w_next = S_HDR0;
            endcase
        end
    end

    // State, counters, word assembly and next-state-decoded registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HDR0;
            r_hdr0     <= 8'h00;
            r_lane     <= 2'd0;
            r_wcnt     <= '0;
            r_last     <= '0;
            r_word     <= 24'h000000;
            r_idle     <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'h0000_0000;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
        end else begin
            r_state   <= w_next;
            imem_we   <= w_write;
            cpu_rst_n <= (w_next == S_RUN);
            busy      <= (w_next == S_HDR0) || (w_next == S_HDR1) ||
                         (w_next == S_LOAD) || (w_next == S_RELEASE);
            err       <= (w_next == S_ERR);
            if (w_write) begin
                imem_waddr <= r_wcnt;
                imem_wdata <= {rx_data, r_word};
            end
            if (boot_req) begin
                r_lane <= 2'd0;
                r_wcnt <= '0;
                r_idle <= '0;
            end else begin
                if (w_accept || (w_next == S_HDR0)) begin
                    r_idle <= '0;
                end else if (w_counting) begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
                if (w_accept && (r_state == S_HDR0)) begin
                    r_hdr0 <= rx_data;
                end
                if (w_accept && (r_state == S_HDR1)) begin
                    r_last <= ADDR_W'(w_count - 17'd1);
                    r_wcnt <= '0;
                    r_lane <= 2'd0;
                end
                // Counter stops at the last address so it never wraps to 0
                if (w_accept && (r_state == S_LOAD)) begin
                    r_lane <= r_lane + 2'd1;
                    r_word <= {rx_data, r_word[23:8]};
                    if ((r_lane == 2'd3) && (r_wcnt != r_last)) begin
                        r_wcnt <= r_wcnt + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: vector table for the basic flow plus
// hand-written sequences for full image, reload, timeout and async reset.
module tb_imem_boot_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_req;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  log_a[$];
    logic [31:0] log_d[$];

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        breq;
        logic        rdy;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        crst;
        logic        bsy;
        logic        er;
    } vec_t;

    vec_t tbl[22];

    imem_boot_ctrl #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .boot_req   (boot_req),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            log_a.push_back(imem_waddr);
            log_d.push_back(imem_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h78, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h00, 32'h12345678,  1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'hEF, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'hBE, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'hAD, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 8'h01, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b0};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        boot_req = 1'b0;
        repeat (3) step();
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_waddr", {24'd0, imem_waddr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Normal load, bad headers, 256-word header
        for (int i = 0; i < 22; i++) begin
            rx_valid = tbl[i].vld;
            rx_data  = tbl[i].data;
            boot_req = tbl[i].breq;
            step();
            chk($sformatf("v%0d_rx_ready", i), {31'd0, rx_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("v%0d_imem_we", i), {31'd0, imem_we}, {31'd0, tbl[i].we});
            chk($sformatf("v%0d_cpu_rst_n", i), {31'd0, cpu_rst_n}, {31'd0, tbl[i].crst});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tbl[i].er});
            if (tbl[i].we) begin
                chk($sformatf("v%0d_waddr", i), {24'd0, imem_waddr}, {24'd0, tbl[i].waddr});
                chk($sformatf("v%0d_wdata", i), imem_wdata, tbl[i].wdata);
            end
        end
        rx_valid = 1'b0;
        boot_req = 1'b0;

        // Full 256-word image (header already accepted), random gaps
        log_a.delete();
        log_d.delete();
        for (int w = 0; w < 256; w++) begin
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 3)) step();
                send_byte((b == 0) ? 8'(w) : 8'h00);
            end
        end
        repeat (4) step();
        chk("full_nwrites", log_a.size(), 32'd256);
        for (int i = 0; i < 256; i++) begin
            if (i < log_a.size()) begin
                chk($sformatf("full_addr%0d", i), {24'd0, log_a[i]}, 32'(i));
                chk($sformatf("full_data%0d", i), log_d[i], 32'(i));
            end
        end
        chk("full_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("full_busy", {31'd0, busy}, 32'd0);
        chk("full_err", {31'd0, err}, 32'd0);

        // Reload from RUN
        pulse_boot();
        chk("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("reload_busy", {31'd0, busy}, 32'd1);
        chk("reload_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        chk("reload_we", {31'd0, imem_we}, 32'd1);
        chk("reload_waddr", {24'd0, imem_waddr}, 32'd0);
        chk("reload_wdata", imem_wdata, 32'h11223344);
        step();
        chk("reload_run", {31'd0, cpu_rst_n}, 32'd1);

        // boot_req coincident with 4th byte: no write, back to HDR0
        pulse_boot();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        rx_valid = 1'b1;
        rx_data  = 8'hDD;
        boot_req = 1'b1;
        step();
        rx_valid = 1'b0;
        boot_req = 1'b0;
        chk("b4_no_we", {31'd0, imem_we}, 32'd0);
        chk("b4_busy", {31'd0, busy}, 32'd1);
        chk("b4_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("b4_next_we", {31'd0, imem_we}, 32'd1);
        chk("b4_next_waddr", {24'd0, imem_waddr}, 32'd0);
        chk("b4_next_wdata", imem_wdata, 32'h04030201);
        step();
        chk("b4_next_run", {31'd0, cpu_rst_n}, 32'd1);

        // Timeout of 16 idle edges after a partial word
        pulse_boot();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hA1); send_byte(8'hA2);
        log_a.delete();
        log_d.delete();
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) begin
                chk("to_err_at15", {31'd0, err}, 32'd0);
                chk("to_busy_at15", {31'd0, busy}, 32'd1);
            end
        end
        chk("to_err_at16", {31'd0, err}, 32'd1);
        chk("to_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("to_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("to_no_writes", log_a.size(), 32'd0);

        // Async reset while a write strobe is high
        pulse_boot();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("ar_pre_we", {31'd0, imem_we}, 32'd1);
        chk("ar_pre_wdata", imem_wdata, 32'h44332211);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_we", {31'd0, imem_we}, 32'd0);
        chk("ar_waddr", {24'd0, imem_waddr}, 32'd0);
        chk("ar_wdata", imem_wdata, 32'd0);
        chk("ar_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd1);
        chk("ar_err", {31'd0, err}, 32'd0);
        chk("ar_rx_ready", {31'd0, rx_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
        chk("ar_new_we", {31'd0, imem_we}, 32'd1);
        chk("ar_new_waddr", {24'd0, imem_waddr}, 32'd0);
        chk("ar_new_wdata", imem_wdata, 32'hAABBCCDD);
        step();
        chk("ar_new_run", {31'd0, cpu_rst_n}, 32'd1);
        chk("ar_new_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer for the single-cycle RV32 core. It holds the core in reset and receives a program image as a byte stream. It assembles the stream into 32-bit little-endian words and writes them into the 256-word instruction memory addressed by the core's `rom_addr`. It then releases the core, and re-runs the load when asked.

## Interface
Parameters:
- `ADDR_W`, default 8. Instruction-memory word-address width. Capacity is `2**ADDR_W` words.
- `TIMEOUT`, default 1000000. Maximum idle cycles allowed between consecutive bytes of one image.

Ports:
- `clk` input 1. Single clock. All state changes on the rising edge.
- `rst_n` input 1. Asynchronous, active-low reset.
- `rx_data` input 8. Incoming image byte.
- `rx_valid` input 1. `rx_data` is valid.
- `rx_ready` output 1. Ready to accept a byte. Combinational decode of the state register.
- `boot_req` input 1. Single-cycle pulse that restarts a load.
- `imem_we` output 1. Instruction-memory write strobe, one cycle per word.
- `imem_waddr` output `ADDR_W`. Word address of the write.
- `imem_wdata` output 32. Word being written.
- `cpu_rst_n` output 1. Active-low reset to the core (`pc_reg` and `registers`).
- `busy` output 1. Load in progress (HDR0, HDR1, LOAD or RELEASE).
- `err` output 1. Last load failed.

## Operation
- A byte is accepted on a rising edge where `rx_valid` and `rx_ready` are both high.
- Image format:
  - Bytes 0 and 1 are `word_count`, 16-bit little-endian.
  - These are followed by `4*word_count` payload bytes, little-endian within each word.
  - Words are written to addresses 0, 1, 2, … in order.
- Valid `word_count` range is 1 to `2**ADDR_W`. A value outside this range goes to ERR.
- States:
  - HDR0: `rx_ready`=1. Waits with no time limit for header byte 0, then goes to HDR1.
  - HDR1: `rx_ready`=1. On header byte 1:
    - if the count is valid, go to LOAD;
    - otherwise go to ERR.
  - LOAD: `rx_ready`=1. A 2-bit byte lane counter shifts bytes into the word.
    - On the 4th byte, register `imem_we`=1 together with its `imem_waddr` and `imem_wdata`.
    - The word counter then increments.
    - On the last byte of the last word, go to RELEASE.
  - RELEASE: `rx_ready`=0. This is the cycle in which the final `imem_we` is high. Go to RUN next.
  - RUN: `rx_ready`=0, `cpu_rst_n`=1. Stays here until `boot_req`.
  - ERR: `rx_ready`=0, `err`=1, `cpu_rst_n`=0. Stays here until `boot_req`.
- `cpu_rst_n`, `busy`, `err`, `imem_we`, `imem_waddr` and `imem_wdata` are registered, decoded from the next state.
- `cpu_rst_n`=1 only in RUN.
- Timeout:
  - The idle counter is cleared on every accepted byte and on entry to HDR0.
  - It counts in HDR1 and LOAD only.
  - Reaching `TIMEOUT` cycles without an accepted byte goes to ERR.
- `boot_req` in any state:
  - Next state is HDR0. Word, lane and idle counters are cleared, and `err` is cleared.
  - `cpu_rst_n` is driven 0 at the same edge.
- `boot_req` together with an accepted byte: `boot_req` wins. The byte is consumed and discarded.
- `boot_req` together with a 4th-byte acceptance: no write occurs.
- `imem_waddr` never exceeds `word_count-1`. Address `2**ADDR_W - 1` is the last write of a full image, and no wrap to 0 occurs.
- Bytes offered while `rx_ready`=0 are ignored. The upstream holds them.

## Timing
- Reset values:
  - state HDR0, so `rx_ready`=1;
  - `cpu_rst_n`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0;
  - `busy`=1, `err`=0.
- Write latency: `imem_we` is high in the cycle after the edge that accepts the word's 4th byte. It lasts exactly 1 cycle.
- Release: with the last byte accepted at edge E, `imem_we`=1 during E to E+1. `cpu_rst_n` rises at E+1 and `busy` falls at E+1.
- Back-to-back bytes are accepted every cycle. Throughput is 1 byte per cycle.
- `boot_req` at edge B: `cpu_rst_n`=0, `busy`=1 and `rx_ready`=1 after B.
- Error detection:
  - Bad count is flagged 1 edge after header byte 1, when `err`=1.
  - Timeout is flagged at the edge where the idle count reaches `TIMEOUT`.
- Asserting `rst_n` mid-load returns all outputs to their reset values immediately. Partially written memory contents are left as-is.

## Test plan
- Normal load: after reset, send 02 00 78 56 34 12 EF BE AD DE back-to-back.
  - Expect `imem_we` with addr 0 and data 0x12345678, then addr 1 and data 0xDEADBEEF.
  - Expect `cpu_rst_n` to rise 1 cycle after the final `imem_we`, with `busy`=0 and `err`=0.
- Bad headers:
  - 00 00 gives `err`=1 after 1 cycle, with `cpu_rst_n` held at 0.
  - After `boot_req`, header 01 01 (257) gives `err`=1.
  - After `boot_req`, header 00 01 (256) proceeds to LOAD.
- Full image: 256 words with `wdata` = address, and random `rx_valid` gaps. Expect 256 writes, addresses 0x00 to 0xFF in order, and no write after 0xFF.
- Timeout with `TIMEOUT`=16: send header 01 00 and 2 payload bytes, then idle. Expect `err`=1 at the 16th idle edge, with no `imem_we`.
- Reload from RUN: pulse `boot_req`. Expect `cpu_rst_n`=0 the next cycle, then a new 1-word image loads to addr 0.
  - Also pulse `boot_req` on the 4th-byte acceptance in LOAD. Expect no write and a return to HDR0.
- Async reset mid-LOAD: all outputs take reset values immediately. A fresh image then loads correctly.
